clk_div_prog: RTL and testbench

CLK_DIV_PROG -- requirements
Module: clk_div_prog

---
 rtl/clk_div_prog_if.sv | 28 ++
 rtl/clk_div_prog.sv | 101 ++++++++++
 tb/tb_clk_div_prog.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/clk_div_prog_if.sv
// clk_div_prog_if: control/status bundle for the programmable clock-enable divider.
//   master : drives enable, mode, start, load, div_in, clr_cnt; observes outputs
//   slave  : the divider; drives clock_en, busy, count, pulse_cnt
interface clk_div_prog_if #(
    parameter int WIDTH     = 25,
    parameter int CNT_WIDTH = 16
);
    logic                 enable;
    logic                 mode;
    logic                 start;
    logic                 load;
    logic [WIDTH-1:0]     div_in;
    logic                 clr_cnt;
    logic                 clock_en;
    logic                 busy;
    logic [WIDTH-1:0]     count;
    logic [CNT_WIDTH-1:0] pulse_cnt;

    modport master (
        output enable, mode, start, load, div_in, clr_cnt,
        input  clock_en, busy, count, pulse_cnt
    );

    modport slave (
        input  enable, mode, start, load, div_in, clr_cnt,
        output clock_en, busy, count, pulse_cnt
    );
endinterface

// File: rtl/clk_div_prog.sv
// clk_div_prog: programmable interval counter producing a registered one-cycle
// clock_en pulse every div+1 enabled cycles (periodic) or once per start
// (one-shot), plus a saturating count of issued pulses.
//   clock    : rising-edge system clock
//   reset    : asynchronous, active-high; clears all state
//   bus      : slave modport of clk_div_prog_if
//              in : enable, mode (0 periodic / 1 one-shot), start, load, div_in, clr_cnt
//              out: clock_en, busy, count, pulse_cnt
module clk_div_prog #(
    parameter int                 WIDTH     = 25,
    parameter logic [WIDTH-1:0]   DIV_RESET = {WIDTH{1'b1}},
    parameter int                 CNT_WIDTH = 16
) (
    input  logic          clock,
    input  logic          reset,
    clk_div_prog_if.slave bus
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     count_q, count_d;
    logic [WIDTH-1:0]     div_q, div_d;
    logic                 mode_q;
    logic                 clk_en_q, clk_en_d;
    logic [CNT_WIDTH-1:0] pulse_q, pulse_d;

    logic mode_chg;
    logic advance;
    logic tc;

    // mode_q remembers the mode seen at the previous edge so a switch can be
    // detected and the interval abandoned cleanly.
    assign mode_chg = bus.mode != mode_q;
    assign advance  = bus.enable && (!bus.mode || state_q == RUN);
    assign tc       = advance && (count_q == div_q);

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        clk_en_d = 1'b0;
        div_d    = bus.load ? bus.div_in : div_q;

        if (mode_chg) begin
            state_d = IDLE;
            count_d = '0;
        end else begin
            // Terminal count compares against the divisor before any load on
            // this edge, so a coinciding load still yields the old pulse.
            clk_en_d = tc;
            if (advance)
                count_d = tc ? '0 : count_q + 1'b1;

            case (state_q)
                IDLE: if (bus.mode && bus.start && bus.enable) begin
                    state_d = RUN;
                    count_d = '0;
                end
                RUN:  if (tc) state_d = IDLE;
                default: state_d = IDLE;
            endcase

            // load restarts the interval but leaves the FSM where it is.
            if (bus.load)
                count_d = '0;
        end
    end

    // clr_cnt wins over a same-cycle increment.
    always_comb begin
        pulse_d = pulse_q;
        if (bus.clr_cnt)
            pulse_d = '0;
        else if (clk_en_q && (pulse_q != {CNT_WIDTH{1'b1}}))
            pulse_d = pulse_q + 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            div_q    <= DIV_RESET;
            mode_q   <= 1'b0;
            clk_en_q <= 1'b0;
            pulse_q  <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            div_q    <= div_d;
            mode_q   <= bus.mode;
            clk_en_q <= clk_en_d;
            pulse_q  <= pulse_d;
        end
    end

    assign bus.clock_en  = clk_en_q;
    assign bus.busy      = bus.mode && (state_q == RUN);
    assign bus.count     = count_q;
    assign bus.pulse_cnt = pulse_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// tb_clk_div_prog: scenario bench for clk_div_prog at WIDTH=4, CNT_WIDTH=2.
// Expected pulse edges are queued per scenario and popped as edges elapse.
module tb_clk_div_prog;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   ncmp  = 0;
    int   nerr  = 0;
    int   exp_q[$];

    clk_div_prog_if #(.WIDTH(4), .CNT_WIDTH(2)) bus ();

    clk_div_prog #(.WIDTH(4), .CNT_WIDTH(2)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.enable  = 1'b0;
        bus.mode    = 1'b0;
        bus.start   = 1'b0;
        bus.load    = 1'b0;
        bus.div_in  = '0;
        bus.clr_cnt = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        exp_q.delete();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        #1 reset = 1'b1;
        #2;
        ncmp++; if (bus.count !== 4'd0)     begin nerr++; $display("FAIL reset_count: got %0d want 0", bus.count); end
        ncmp++; if (bus.clock_en !== 1'b0)  begin nerr++; $display("FAIL reset_clock_en: got %b want 0", bus.clock_en); end
        ncmp++; if (bus.busy !== 1'b0)      begin nerr++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        ncmp++; if (bus.pulse_cnt !== 2'd0) begin nerr++; $display("FAIL reset_pulse_cnt: got %0d want 0", bus.pulse_cnt); end
        bus.enable = 1'b1;
        step();
        ncmp++; if (bus.count !== 4'd0)     begin nerr++; $display("FAIL reset_hold_count: got %0d want 0", bus.count); end
        do_reset();
    endtask

    // Default divisor 15: pulse after every 16th enabled edge.
    task automatic test_default_period();
        bit exp;
        do_reset();
        bus.enable = 1'b1;
        exp_q.push_back(16);
        exp_q.push_back(32);
        for (int e = 1; e <= 34; e++) begin
            step();
            exp = (exp_q.size() > 0 && exp_q[0] == e);
            if (exp) void'(exp_q.pop_front());
            ncmp++;
            if (bus.clock_en !== exp) begin
                nerr++; $display("FAIL default_period edge %0d: clock_en=%b want %b", e, bus.clock_en, exp);
            end
        end
        ncmp++; if (exp_q.size() != 0) begin nerr++; $display("FAIL default_period_missing: %0d pulses left want 0", exp_q.size()); end
        ncmp++; if (bus.pulse_cnt !== 2'd2) begin nerr++; $display("FAIL default_pulse_cnt: got %0d want 2", bus.pulse_cnt); end
    endtask

    task automatic test_periodic();
        bit exp;
        do_reset();
        bus.load = 1'b1; bus.div_in = 4'd3;
        step();
        bus.load = 1'b0; bus.enable = 1'b1;
        exp_q = '{4, 8, 12};
        for (int e = 1; e <= 13; e++) begin
            if (e == 13) bus.enable = 1'b0;
            step();
            exp = (exp_q.size() > 0 && exp_q[0] == e);
            if (exp) void'(exp_q.pop_front());
            ncmp++;
            if (bus.clock_en !== exp) begin
                nerr++; $display("FAIL periodic edge %0d: clock_en=%b want %b", e, bus.clock_en, exp);
            end
        end
        ncmp++; if (bus.pulse_cnt !== 2'd3) begin nerr++; $display("FAIL periodic_pulse_cnt: got %0d want 3", bus.pulse_cnt); end
        ncmp++; if (bus.count !== 4'd0)     begin nerr++; $display("FAIL periodic_frozen_count: got %0d want 0", bus.count); end
    endtask

    task automatic test_oneshot();
        bit exp;
        int busy_cycles;
        do_reset();
        bus.mode = 1'b1; bus.load = 1'b1; bus.div_in = 4'd5;
        step();
        bus.load = 1'b0; bus.enable = 1'b1; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        ncmp++; if (bus.busy !== 1'b1)  begin nerr++; $display("FAIL oneshot_start_busy: got %b want 1", bus.busy); end
        ncmp++; if (bus.count !== 4'd0) begin nerr++; $display("FAIL oneshot_start_count: got %0d want 0", bus.count); end
        busy_cycles = 1;
        exp_q = '{6};
        for (int e = 1; e <= 12; e++) begin
            bus.start = (e == 3);
            step();
            exp = (exp_q.size() > 0 && exp_q[0] == e);
            if (exp) void'(exp_q.pop_front());
            if (bus.busy === 1'b1) busy_cycles++;
            ncmp++;
            if (bus.clock_en !== exp) begin
                nerr++; $display("FAIL oneshot edge %0d: clock_en=%b want %b", e, bus.clock_en, exp);
            end
            ncmp++;
            if (bus.busy !== (e < 6)) begin
                nerr++; $display("FAIL oneshot_busy edge %0d: busy=%b want %b", e, bus.busy, (e < 6));
            end
        end
        bus.start = 1'b0;
        ncmp++; if (busy_cycles != 6)   begin nerr++; $display("FAIL oneshot_busy_len: got %0d want 6", busy_cycles); end
        ncmp++; if (bus.count !== 4'd0) begin nerr++; $display("FAIL oneshot_end_count: got %0d want 0", bus.count); end
    endtask

    task automatic test_midrun_load();
        bit exp;
        do_reset();
        bus.load = 1'b1; bus.div_in = 4'd7;
        step();
        bus.load = 1'b0; bus.enable = 1'b1;
        exp_q = '{9, 12, 15};
        for (int e = 1; e <= 15; e++) begin
            bus.load = (e == 6);
            bus.div_in = 4'd2;
            step();
            exp = (exp_q.size() > 0 && exp_q[0] == e);
            if (exp) void'(exp_q.pop_front());
            ncmp++;
            if (bus.clock_en !== exp) begin
                nerr++; $display("FAIL midrun_load edge %0d: clock_en=%b want %b", e, bus.clock_en, exp);
            end
            if (e == 5) begin
                ncmp++; if (bus.count !== 4'd5) begin nerr++; $display("FAIL midrun_pre_count: got %0d want 5", bus.count); end
            end
            if (e == 6) begin
                ncmp++; if (bus.count !== 4'd0) begin nerr++; $display("FAIL midrun_load_count: got %0d want 0", bus.count); end
            end
        end
        bus.load = 1'b0;
    endtask

    task automatic test_pause_reset();
        bit exp;
        do_reset();
        bus.load = 1'b1; bus.div_in = 4'd7;
        step();
        bus.load = 1'b0; bus.enable = 1'b1;
        step(); step();
        ncmp++; if (bus.count !== 4'd2) begin nerr++; $display("FAIL pause_pre_count: got %0d want 2", bus.count); end
        bus.enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            ncmp++;
            if (bus.count !== 4'd2 || bus.clock_en !== 1'b0) begin
                nerr++; $display("FAIL pause cycle %0d: count=%0d clock_en=%b want 2/0", i, bus.count, bus.clock_en);
            end
        end
        bus.enable = 1'b1;
        exp_q = '{6};
        for (int e = 1; e <= 7; e++) begin
            step();
            exp = (exp_q.size() > 0 && exp_q[0] == e);
            if (exp) void'(exp_q.pop_front());
            ncmp++;
            if (bus.clock_en !== exp) begin
                nerr++; $display("FAIL pause_resume edge %0d: clock_en=%b want %b", e, bus.clock_en, exp);
            end
        end
        ncmp++; if (bus.pulse_cnt !== 2'd1) begin nerr++; $display("FAIL pause_pulse_cnt: got %0d want 1", bus.pulse_cnt); end
        ncmp++; if (bus.count !== 4'd1)     begin nerr++; $display("FAIL pause_count: got %0d want 1", bus.count); end
        #2 reset = 1'b1;
        #1;
        ncmp++; if (bus.count !== 4'd0)     begin nerr++; $display("FAIL async_reset_count: got %0d want 0", bus.count); end
        ncmp++; if (bus.pulse_cnt !== 2'd0) begin nerr++; $display("FAIL async_reset_pulse_cnt: got %0d want 0", bus.pulse_cnt); end
        #2 reset = 1'b0;
        step();
        ncmp++; if (bus.count !== 4'd1)     begin nerr++; $display("FAIL reset_resume_count: got %0d want 1", bus.count); end
        ncmp++; if (bus.clock_en !== 1'b0)  begin nerr++; $display("FAIL reset_resume_clock_en: got %b want 0", bus.clock_en); end
    endtask

    task automatic test_saturation();
        int pexp;
        do_reset();
        bus.load = 1'b1; bus.div_in = 4'd0;
        step();
        bus.load = 1'b0; bus.enable = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            bus.clr_cnt = (e == 9);
            step();
            pexp = (e == 9) ? 0 : (e == 10) ? 1 : ((e - 1) > 3 ? 3 : e - 1);
            ncmp++;
            if (bus.clock_en !== 1'b1) begin
                nerr++; $display("FAIL sat_clock_en edge %0d: got %b want 1", e, bus.clock_en);
            end
            ncmp++;
            if (bus.pulse_cnt !== pexp[1:0]) begin
                nerr++; $display("FAIL sat_pulse_cnt edge %0d: got %0d want %0d", e, bus.pulse_cnt, pexp);
            end
        end
        bus.clr_cnt = 1'b0;
        #2 reset = 1'b1;
        #1;
        ncmp++; if (bus.clock_en !== 1'b0)  begin nerr++; $display("FAIL async_reset_clock_en: got %b want 0", bus.clock_en); end
        ncmp++; if (bus.pulse_cnt !== 2'd0) begin nerr++; $display("FAIL async_reset_sat_cnt: got %0d want 0", bus.pulse_cnt); end
        ncmp++; if (bus.busy !== 1'b0)      begin nerr++; $display("FAIL async_reset_busy: got %b want 0", bus.busy); end
        #2 reset = 1'b0;
    endtask

    // load+start together, load at terminal count, mode switch at terminal count.
    task automatic test_boundaries();
        bit exp;
        do_reset();
        bus.mode = 1'b1;
        step();
        bus.enable = 1'b1; bus.start = 1'b1; bus.load = 1'b1; bus.div_in = 4'd2;
        step();
        bus.start = 1'b0; bus.load = 1'b0;
        ncmp++; if (bus.busy !== 1'b1)  begin nerr++; $display("FAIL load_start_busy: got %b want 1", bus.busy); end
        ncmp++; if (bus.count !== 4'd0) begin nerr++; $display("FAIL load_start_count: got %0d want 0", bus.count); end
        exp_q = '{3};
        for (int e = 1; e <= 5; e++) begin
            step();
            exp = (exp_q.size() > 0 && exp_q[0] == e);
            if (exp) void'(exp_q.pop_front());
            ncmp++;
            if (bus.clock_en !== exp || bus.busy !== (e < 3)) begin
                nerr++; $display("FAIL load_start edge %0d: clock_en=%b busy=%b want %b/%b", e, bus.clock_en, bus.busy, exp, (e < 3));
            end
        end
        bus.mode = 1'b0;
        step();
        exp_q = '{3, 8};
        for (int e = 1; e <= 16; e++) begin
            bus.load   = (e == 3);
            bus.div_in = 4'd4;
            bus.mode   = (e >= 13);
            step();
            exp = (exp_q.size() > 0 && exp_q[0] == e);
            if (exp) void'(exp_q.pop_front());
            ncmp++;
            if (bus.clock_en !== exp) begin
                nerr++; $display("FAIL tc_load_mode edge %0d: clock_en=%b want %b", e, bus.clock_en, exp);
            end
            if (e == 3 || e == 13) begin
                ncmp++; if (bus.count !== 4'd0) begin nerr++; $display("FAIL tc_count edge %0d: got %0d want 0", e, bus.count); end
            end
            if (e == 12) begin
                ncmp++; if (bus.count !== 4'd4) begin nerr++; $display("FAIL pre_mode_count: got %0d want 4", bus.count); end
            end
        end
        ncmp++; if (bus.busy !== 1'b0) begin nerr++; $display("FAIL mode_switch_busy: got %b want 0", bus.busy); end
        bus.load = 1'b0;
    endtask

    initial begin
        test_reset();
        test_default_period();
        test_periodic();
        test_oneshot();
        test_midrun_load();
        test_pause_reset();
        test_saturation();
        test_boundaries();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
